// File: rtl/ppu_pkg.sv
// Shared PPU types and framebuffer geometry used by the pixel sink and its FIFO.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } PPU_STATES_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_BUSY = 1'b1
  } wr_state_t;

  localparam int FB_BYTES_PER_LINE = 40;
  localparam int FB_ADDR_W         = 13;
  localparam int FB_ENTRY_W        = FB_ADDR_W + 8;

  // Drop pixel px into slot idx of a byte; slot 0 is the most significant pair.
  function automatic logic [7:0] pack_px(input logic [7:0] acc, input logic [1:0] idx,
                                         input logic [1:0] px);
    logic [7:0] r;
    r = acc;
    case (idx)
      2'd0:    r[7:6] = px;
      2'd1:    r[5:4] = px;
      2'd2:    r[3:2] = px;
      default: r[1:0] = px;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ppu_byte_fifo.sv
// Small synchronous FIFO of {addr, data} framebuffer writes; exposes the head and
// the entry behind it so the writer can issue back-to-back requests.
module ppu_byte_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FB_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W-1:0] head_next,
  output logic         full,
  output logic         empty,
  output logic         more_than_one
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nxt;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full          = (cnt_q == (AW+1)'(DEPTH));
  assign empty         = (cnt_q == '0);
  assign more_than_one = (cnt_q > (AW+1)'(1));
  assign rd_nxt        = rd_q + 1'b1;
  assign head          = mem_q[rd_q];
  assign head_next     = mem_q[rd_nxt];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_nxt;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ppu_frame_writer.sv
// PPU pixel sink: packs 2-bit pixels four per byte, queues them and writes them
// into the framebuffer over a write/ack port, flagging frame completion.
module ppu_frame_writer
  import ppu_pkg::*;
#(
  parameter int H_PIXELS   = 4 * FB_BYTES_PER_LINE,
  parameter int V_LINES    = 144,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           PX_IN,
  input  logic                 PX_valid,
  input  logic [1:0]           PPU_MODE,
  output logic                 FB_WR,
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic [7:0]           FB_DATA,
  input  logic                 FB_ACK,
  input  logic                 CLR_OVF,
  output logic [7:0]           LINE_CNT,
  output logic                 FRAME_DONE,
  output logic                 OVERFLOW,
  output logic                 dbg_wr_state
);

  localparam logic [7:0]           H_LIM = 8'(H_PIXELS);
  localparam logic [7:0]           V_LIM = 8'(V_LINES);
  localparam logic [FB_ADDR_W-1:0] BPL   = FB_ADDR_W'(H_PIXELS / 4);

  PPU_STATES_t          mode, mode_prev_q;
  logic [7:0]           x_cnt_q, x_cnt_d, acc_q, acc_d, acc_next;
  logic [1:0]           pix_idx_q, pix_idx_d;
  logic [7:0]           line_cnt_q, line_cnt_d;
  logic [FB_ADDR_W-1:0] line_base_q, line_base_d, addr_cur;
  logic                 frame_pending_q, frame_pending_d;
  logic                 frame_done_q, frame_done_d;
  logic                 ovf_q, ovf_d;
  wr_state_t            wr_state_q, wr_state_d;
  logic                 fb_wr_q, fb_wr_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]           fb_data_q, fb_data_d;

  logic                  capture, line_end, frame_end, done_fire;
  logic                  push, pop;
  logic [FB_ENTRY_W-1:0] push_data, fifo_head, fifo_head_next;
  logic                  fifo_full, fifo_empty, fifo_more;

  assign mode     = PPU_STATES_t'(PPU_MODE);
  assign addr_cur = line_base_q + FB_ADDR_W'(x_cnt_q[7:2]);
  assign acc_next = pack_px(acc_q, pix_idx_q, PX_IN);

  assign capture   = PX_valid && (mode == DRAW) && (x_cnt_q < H_LIM) && (line_cnt_q < V_LIM);
  assign line_end  = (mode_prev_q == DRAW) && (mode != DRAW);
  assign frame_end = (mode == V_BLANK) && (mode_prev_q != V_BLANK);
  assign done_fire = frame_pending_q && fifo_empty && (wr_state_q == WR_IDLE);
  assign pop       = (wr_state_q == WR_BUSY) && FB_ACK;

  always_comb begin
    push            = 1'b0;
    push_data       = {addr_cur, acc_q};
    x_cnt_d         = x_cnt_q;
    pix_idx_d       = pix_idx_q;
    acc_d           = acc_q;
    line_cnt_d      = line_cnt_q;
    line_base_d     = line_base_q;
    frame_pending_d = frame_pending_q && !done_fire;
    if (capture) begin
      if (pix_idx_q == 2'd3) begin
        push      = 1'b1;
        push_data = {addr_cur, acc_next};
        x_cnt_d   = x_cnt_q + 8'd4;
        pix_idx_d = 2'd0;
        acc_d     = 8'h00;
      end else begin
        pix_idx_d = pix_idx_q + 2'd1;
        acc_d     = acc_next;
      end
    end
    // Partial groups leave with zeroed low slots, at the address of the line just ended.
    if (line_end) begin
      push        = (pix_idx_q != 2'd0);
      x_cnt_d     = 8'd0;
      pix_idx_d   = 2'd0;
      acc_d       = 8'h00;
      line_cnt_d  = line_cnt_q + 8'd1;
      line_base_d = line_base_q + BPL;
    end
    if (frame_end) begin
      line_cnt_d      = 8'd0;
      line_base_d     = '0;
      frame_pending_d = 1'b1;
    end
  end

  always_comb begin
    frame_done_d = done_fire;
    ovf_d        = ovf_q;
    if (CLR_OVF) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  // Writer: request stays up with stable addr/data until acknowledged.
  always_comb begin
    wr_state_d = wr_state_q;
    fb_wr_d    = fb_wr_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (!fifo_empty) begin
          wr_state_d             = WR_BUSY;
          fb_wr_d                = 1'b1;
          {fb_addr_d, fb_data_d} = fifo_head;
        end
      end
      WR_BUSY: begin
        if (FB_ACK) begin
          if (fifo_more) begin
            fb_wr_d                = 1'b1;
            {fb_addr_d, fb_data_d} = fifo_head_next;
          end else begin
            wr_state_d = WR_IDLE;
            fb_wr_d    = 1'b0;
          end
        end
      end
      default: begin
        wr_state_d = WR_IDLE;
        fb_wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_prev_q     <= H_BLANK;
      x_cnt_q         <= 8'd0;
      pix_idx_q       <= 2'd0;
      acc_q           <= 8'h00;
      line_cnt_q      <= 8'd0;
      line_base_q     <= '0;
      frame_pending_q <= 1'b0;
      frame_done_q    <= 1'b0;
      ovf_q           <= 1'b0;
      wr_state_q      <= WR_IDLE;
      fb_wr_q         <= 1'b0;
      fb_addr_q       <= '0;
      fb_data_q       <= 8'h00;
    end else begin
      mode_prev_q     <= mode;
      x_cnt_q         <= x_cnt_d;
      pix_idx_q       <= pix_idx_d;
      acc_q           <= acc_d;
      line_cnt_q      <= line_cnt_d;
      line_base_q     <= line_base_d;
      frame_pending_q <= frame_pending_d;
      frame_done_q    <= frame_done_d;
      ovf_q           <= ovf_d;
      wr_state_q      <= wr_state_d;
      fb_wr_q         <= fb_wr_d;
      fb_addr_q       <= fb_addr_d;
      fb_data_q       <= fb_data_d;
    end
  end

  ppu_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(FB_ENTRY_W)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .head         (fifo_head),
    .head_next    (fifo_head_next),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .more_than_one(fifo_more)
  );

  assign FB_WR        = fb_wr_q;
  assign FB_ADDR      = fb_addr_q;
  assign FB_DATA      = fb_data_q;
  assign LINE_CNT     = line_cnt_q;
  assign FRAME_DONE   = frame_done_q;
  assign OVERFLOW     = ovf_q;
  assign dbg_wr_state = wr_state_q;

endmodule

// File: tb/tb_ppu_frame_writer.sv
// Bench for ppu_frame_writer: line-level reference model of the framebuffer writes,
// compared against the write stream captured from the DUT.
module tb_ppu_frame_writer;

  localparam logic [1:0] M_HB = 2'd0, M_VB = 2'd1, M_SC = 2'd2, M_DR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  px_in = 2'd0;
  logic        px_valid = 1'b0;
  logic [1:0]  ppu_mode = M_HB;
  logic        fb_wr, fb_ack, frame_done, overflow, dbg_wr_state;
  logic        clr_ovf = 1'b0;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data, line_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_mode = 0;
  int done_cnt = 0;
  int done_after = 0;

  logic [20:0] exp_q[$];
  logic [20:0] act_q[$];

  int         m_line = 0;
  int         m_cap = 1000;
  logic [1:0] m_prev = M_HB;
  logic [1:0] m_px[$];

  ppu_frame_writer dut (
    .clk(clk), .rst(rst), .PX_IN(px_in), .PX_valid(px_valid), .PPU_MODE(ppu_mode),
    .FB_WR(fb_wr), .FB_ADDR(fb_addr), .FB_DATA(fb_data), .FB_ACK(fb_ack),
    .CLR_OVF(clr_ovf), .LINE_CNT(line_cnt), .FRAME_DONE(frame_done),
    .OVERFLOW(overflow), .dbg_wr_state(dbg_wr_state)
  );

  // clock / reset-independent infrastructure
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb fb_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? 1'b0 : ((cyc % 3) == 0);

  always @(negedge clk) begin
    if (!rst && fb_wr && fb_ack) act_q.push_back({fb_addr, fb_data});
    if (frame_done) begin
      done_cnt++;
      done_after = act_q.size();
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: a line's accepted pixels become bytes line*40+g when the line ends.
  task automatic model_line_end();
    int nb;
    logic [7:0] b;
    if (m_line < 144) begin
      nb = (m_px.size() + 3) / 4;
      if (nb > m_cap) nb = m_cap;
      for (int g = 0; g < nb; g++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++)
          if (4 * g + k < m_px.size()) b[7-2*k -: 2] = m_px[4*g+k];
        exp_q.push_back({13'(m_line * 40 + g), b});
      end
    end
    m_px.delete();
    m_line++;
  endtask

  task automatic drive(input logic v, input logic [1:0] p, input logic [1:0] mode,
                       input logic clr = 1'b0);
    px_valid = v;
    px_in    = p;
    ppu_mode = mode;
    clr_ovf  = clr;
    if (m_prev == M_DR && mode != M_DR) model_line_end();
    if (mode == M_VB && m_prev != M_VB) m_line = 0;
    if (v && mode == M_DR && m_px.size() < 160) m_px.push_back(p);
    m_prev = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_line = 0;
    m_px.delete();
    m_prev = M_HB;
    m_cap = 1000;
    exp_q.delete();
    act_q.delete();
    done_cnt = 0;
    done_after = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    px_valid = 1'b0;
    px_in = 2'd0;
    ppu_mode = M_HB;
    clr_ovf = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drain(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      drive(1'b0, 2'd0, ppu_mode);
      if (!fb_wr) quiet++;
      else quiet = 0;
      n++;
    end
    checks++;
    if (quiet < 4) begin
      errors++;
      $display("FAIL %s drain: writer still busy after %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 7;
    if (fb_wr !== 1'b0)       begin errors++; $display("FAIL reset FB_WR: got %b want 0", fb_wr); end
    if (fb_addr !== 13'd0)    begin errors++; $display("FAIL reset FB_ADDR: got %0d want 0", fb_addr); end
    if (fb_data !== 8'h00)    begin errors++; $display("FAIL reset FB_DATA: got %h want 00", fb_data); end
    if (line_cnt !== 8'd0)    begin errors++; $display("FAIL reset LINE_CNT: got %0d want 0", line_cnt); end
    if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset FRAME_DONE: got %b want 0", frame_done); end
    if (overflow !== 1'b0)    begin errors++; $display("FAIL reset OVERFLOW: got %b want 0", overflow); end
    if (dbg_wr_state !== 1'b0) begin errors++; $display("FAIL reset writer state: got %b want idle", dbg_wr_state); end
  endtask

  task automatic test_full_line();
    ack_mode = 0;
    drive(1'b0, 2'd0, M_SC);
    for (int i = 0; i < 160; i++) begin
      drive(1'b1, 2'(i % 4), M_DR);
      if (i == 3) begin
        checks++;
        if (fb_wr !== 1'b0) begin errors++; $display("FAIL latency early FB_WR: got %b want 0", fb_wr); end
      end
      if (i == 4) begin
        checks++;
        if ({fb_wr, fb_addr, fb_data} !== {1'b1, 13'd0, 8'h1B}) begin
          errors++;
          $display("FAIL latency first write: got wr=%b addr=%0d data=%h want wr=1 addr=0 data=1b",
                   fb_wr, fb_addr, fb_data);
        end
      end
    end
    repeat (3) drive(1'b0, 2'd0, M_HB);
    drain("full_line");
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL full_line count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_line write %0d: got %0d/%h want %0d/%h", i, act_q[i][20:8], act_q[i][7:0], exp_q[i][20:8], exp_q[i][7:0]); end
    end
    checks++;
    if (line_cnt !== 8'd1) begin errors++; $display("FAIL full_line LINE_CNT: got %0d want 1", line_cnt); end
  endtask

  task automatic test_partial_flush();
    exp_q.delete();
    act_q.delete();
    repeat (2) drive(1'b0, 2'd0, M_DR);
    repeat (2) drive(1'b0, 2'd0, M_HB);
    repeat (6) drive(1'b1, 2'd3, M_DR);
    repeat (3) drive(1'b0, 2'd0, M_HB);
    drain("partial");
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL partial count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL partial write %0d: got %0d/%h want %0d/%h", i, act_q[i][20:8], act_q[i][7:0], exp_q[i][20:8], exp_q[i][7:0]); end
    end
    checks++;
    if (line_cnt !== 8'd3) begin errors++; $display("FAIL partial LINE_CNT: got %0d want 3", line_cnt); end
  endtask

  task automatic test_ignore_modes();
    act_q.delete();
    exp_q.delete();
    for (int i = 0; i < 40; i++)
      drive(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 1) * 2));
    drive(1'b0, 2'd0, M_HB);
    drain("ignore");
    checks += 2;
    if (act_q.size() !== 0) begin errors++; $display("FAIL ignore writes: got %0d want 0", act_q.size()); end
    if (line_cnt !== 8'd3) begin errors++; $display("FAIL ignore LINE_CNT: got %0d want 3", line_cnt); end
  endtask

  task automatic test_random_lines();
    int len;
    int sent;
    act_q.delete();
    exp_q.delete();
    ack_mode = 2;
    for (int ln = 0; ln < 4; ln++) begin
      len = $urandom_range(1, 175);
      sent = 0;
      drive(1'b1, 2'($urandom_range(0, 3)), M_SC);
      while (sent < len) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(1'b1, 2'($urandom_range(0, 3)), M_DR);
          sent++;
        end else begin
          drive(1'b0, 2'($urandom_range(0, 3)), M_DR);
        end
      end
      repeat (3) drive(1'b1, 2'($urandom_range(0, 3)), M_HB);
    end
    drain("random");
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL random count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL random write %0d: got %0d/%h want %0d/%h", i, act_q[i][20:8], act_q[i][7:0], exp_q[i][20:8], exp_q[i][7:0]); end
    end
    checks += 2;
    if (line_cnt !== 8'd7) begin errors++; $display("FAIL random LINE_CNT: got %0d want 7", line_cnt); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL random OVERFLOW: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    act_q.delete();
    exp_q.delete();
    ack_mode = 1;
    m_cap = 4;
    for (int i = 0; i < 24; i++) drive(1'b1, 2'($urandom_range(0, 3)), M_DR);
    repeat (2) drive(1'b0, 2'd0, M_DR);
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow set: got %b want 1", overflow); end
    if ({fb_wr, fb_addr} !== {1'b1, 13'(m_line * 40)}) begin
      errors++;
      $display("FAIL overflow held request: got wr=%b addr=%0d want wr=1 addr=%0d", fb_wr, fb_addr, m_line * 40);
    end
    drive(1'b0, 2'd0, M_DR, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow clear: got %b want 0", overflow); end
    for (int i = 0; i < 3; i++) drive(1'b1, 2'($urandom_range(0, 3)), M_DR);
    drive(1'b1, 2'($urandom_range(0, 3)), M_DR, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow set beats clear: got %b want 1", overflow); end
    drive(1'b0, 2'd0, M_DR, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow second clear: got %b want 0", overflow); end
    drive(1'b0, 2'd0, M_HB);
    ack_mode = 0;
    drain("overflow");
    m_cap = 1000;
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL overflow count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL overflow write %0d: got %0d/%h want %0d/%h", i, act_q[i][20:8], act_q[i][7:0], exp_q[i][20:8], exp_q[i][7:0]); end
    end
  endtask

  task automatic test_frame_flush();
    apply_reset();
    ack_mode = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, 2'($urandom_range(0, 3)), M_DR);
    repeat (3) drive(1'b0, 2'd0, M_VB);
    drain("frame_flush");
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL frame_flush count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_flush write %0d: got %0d/%h want %0d/%h", i, act_q[i][20:8], act_q[i][7:0], exp_q[i][20:8], exp_q[i][7:0]); end
    end
    checks += 3;
    if (line_cnt !== 8'd0) begin errors++; $display("FAIL frame_flush LINE_CNT: got %0d want 0", line_cnt); end
    if (done_cnt !== 1) begin errors++; $display("FAIL frame_flush FRAME_DONE count: got %0d want 1", done_cnt); end
    if (done_after !== 2) begin errors++; $display("FAIL frame_flush FRAME_DONE after writes: got %0d want 2", done_after); end
  endtask

  task automatic test_frame();
    apply_reset();
    ack_mode = 2;
    for (int ln = 0; ln < 144; ln++) begin
      repeat (2) drive(1'b0, 2'd0, M_SC);
      for (int i = 0; i < 160; i++) drive(1'b1, 2'($urandom_range(0, 3)), M_DR);
      repeat (2) drive(1'b0, 2'd0, M_HB);
    end
    repeat (4) drive(1'b0, 2'd0, M_VB);
    drain("frame");
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL frame count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame write %0d: got %0d/%h want %0d/%h", i, act_q[i][20:8], act_q[i][7:0], exp_q[i][20:8], exp_q[i][7:0]); end
    end
    checks += 4;
    if (done_cnt !== 1) begin errors++; $display("FAIL frame FRAME_DONE count: got %0d want 1", done_cnt); end
    if (done_after !== 5760) begin errors++; $display("FAIL frame FRAME_DONE after writes: got %0d want 5760", done_after); end
    if (line_cnt !== 8'd0) begin errors++; $display("FAIL frame LINE_CNT: got %0d want 0", line_cnt); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL frame OVERFLOW: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    ack_mode = 1;
    for (int i = 0; i < 12; i++) drive(1'b1, 2'($urandom_range(0, 3)), M_DR);
    drive(1'b0, 2'd0, M_DR);
    checks++;
    if (fb_wr !== 1'b1) begin errors++; $display("FAIL rst_mid pending FB_WR: got %b want 1", fb_wr); end
    rst = 1'b1;
    px_valid = 1'b0;
    ppu_mode = M_HB;
    @(posedge clk);
    #1;
    checks++;
    if (fb_wr !== 1'b0) begin errors++; $display("FAIL rst_mid FB_WR after reset: got %b want 0", fb_wr); end
    rst = 1'b0;
    model_clear();
    ack_mode = 0;
    repeat (20) drive(1'b0, 2'd0, M_HB);
    checks += 3;
    if (act_q.size() !== 0) begin errors++; $display("FAIL rst_mid writes after reset: got %0d want 0", act_q.size()); end
    if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid FRAME_DONE: got %0d want 0", done_cnt); end
    if (fb_wr !== 1'b0) begin errors++; $display("FAIL rst_mid FB_WR idle: got %b want 0", fb_wr); end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_partial_flush();
    test_ignore_modes();
    test_random_lines();
    test_overflow();
    test_frame_flush();
    test_frame();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
